// File: rtl/uart_frame_builder.sv
// Ping-pong capture of one count per channel, serialised as HEADER, length, [seq], data, checksum.
// Optional sequence byte enabled by defining FRAME_SEQ_EN.
module uart_frame_builder #(
    parameter int          NUM_CH = 16,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start,
    input  logic       sample_valid,
    input  logic [7:0] data_in,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       frame_busy,
    output logic [7:0] overrun_cnt
);
    localparam int IW = $clog2(NUM_CH);
    localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
`ifdef FRAME_SEQ_EN
    localparam logic [2:0] S_SEQ  = 3'd3;
`endif
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_CSUM = 3'd5;

    logic [7:0]    bank_q [2][NUM_CH];
    logic          cap_sel_q, cap_sel_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [2:0]    state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          busy_q, busy_d;
    logic [7:0]    overrun_q, overrun_d;
    logic [7:0]    csum_q, csum_d;
`ifdef FRAME_SEQ_EN
    logic [7:0]    seq_q, seq_d;
`endif

    logic [IW-1:0] cap_idx, rd_nxt;
    logic          frame_done, tx_free, acc, tx_sel;
    logic [7:0]    sum_nxt;

    // start forces this sample (if any) to slot 0, discarding the partial scan
    assign cap_idx    = start ? '0 : wr_idx_q;
    assign frame_done = sample_valid && (cap_idx == LAST);
    assign tx_free    = (state_q == S_IDLE);
    assign acc        = tx_valid_q && tx_ready;
    assign tx_sel     = ~cap_sel_q;
    assign sum_nxt    = csum_q + tx_data_q;
    assign rd_nxt     = rd_idx_q + IW'(1);

    always_comb begin
        wr_idx_d   = wr_idx_q;
        cap_sel_d  = cap_sel_q;
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        csum_d     = csum_q;
`ifdef FRAME_SEQ_EN
        seq_d      = seq_q;
`endif
        if (sample_valid)
            wr_idx_d = frame_done ? '0 : cap_idx + IW'(1);
        else if (start)
            wr_idx_d = '0;

        if (acc) begin
            case (state_q)
                S_HDR: begin
                    state_d   = S_LEN;
                    tx_data_d = 8'(NUM_CH);
                end
                S_LEN: begin
                    csum_d = sum_nxt;
`ifdef FRAME_SEQ_EN
                    state_d   = S_SEQ;
                    tx_data_d = seq_q;
                end
                S_SEQ: begin
                    csum_d = sum_nxt;
`endif
                    state_d   = S_DATA;
                    rd_idx_d  = '0;
                    tx_data_d = bank_q[tx_sel][0];
                end
                S_DATA: begin
                    csum_d = sum_nxt;
                    if (rd_idx_q == LAST) begin
                        state_d   = S_CSUM;
                        tx_data_d = sum_nxt;
                    end else begin
                        rd_idx_d  = rd_nxt;
                        tx_data_d = bank_q[tx_sel][rd_nxt];
                    end
                end
                S_CSUM: begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
`ifdef FRAME_SEQ_EN
                    seq_d      = seq_q + 8'd1;
`endif
                end
                default: ;
            endcase
        end

        // TX side only takes a new frame from IDLE; otherwise the scan is dropped
        if (frame_done) begin
            if (tx_free) begin
                cap_sel_d  = ~cap_sel_q;
                busy_d     = 1'b1;
                state_d    = S_HDR;
                tx_valid_d = 1'b1;
                tx_data_d  = HEADER;
                csum_d     = 8'd0;
            end else if (overrun_q != 8'hFF) begin
                overrun_d = overrun_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (sample_valid)
            bank_q[cap_sel_q][cap_idx] <= data_in;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_idx_q   <= '0;
            cap_sel_q  <= 1'b0;
            state_q    <= S_IDLE;
            rd_idx_q   <= '0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 8'd0;
            csum_q     <= 8'd0;
`ifdef FRAME_SEQ_EN
            seq_q      <= 8'd0;
`endif
        end else begin
            wr_idx_q   <= wr_idx_d;
            cap_sel_q  <= cap_sel_d;
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            csum_q     <= csum_d;
`ifdef FRAME_SEQ_EN
            seq_q      <= seq_d;
`endif
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign frame_busy  = busy_q;
    assign overrun_cnt = overrun_q;
endmodule

// File: tb/tb_uart_frame_builder.sv
// Directed bench for uart_frame_builder: expected bytes queued per frame, checked on each handshake.
module tb_uart_frame_builder;
    localparam int N = 16;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       frame_busy;
    logic [7:0] overrun_cnt;

    uart_frame_builder #(.NUM_CH(N), .HEADER(8'hA5)) dut (
        .clk_in(clk_in), .reset(reset), .start(start), .sample_valid(sample_valid),
        .data_in(data_in), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_busy(frame_busy), .overrun_cnt(overrun_cnt)
    );

    always #5 clk_in = ~clk_in;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];
    logic [7:0] fd[N];
    logic [7:0] seq_m = 8'd0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'd0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    // Monitor samples on the falling edge; stimulus moves #1 after the rising edge.
    always @(negedge clk_in) begin
        if (hold_pend) begin
            chk("hold_valid", {7'd0, tx_valid}, 8'd1);
            chk("hold_data", tx_data, hold_data);
        end
        if (!reset && tx_valid && tx_ready) begin
            if (sb.size() == 0) chk("unexpected_byte", tx_data, 8'hXX);
            else chk("byte", tx_data, sb.pop_front());
        end
        hold_pend = !reset && tx_valid && !tx_ready;
        hold_data = tx_data;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_sample(input logic [7:0] d, input logic st);
        start = st; sample_valid = 1'b1; data_in = d;
        tick();
        start = 1'b0; sample_valid = 1'b0;
    endtask

    task automatic scan(input logic use_start);
        for (int i = 0; i < N; i++) send_sample(fd[i], use_start && i == 0);
    endtask

    task automatic push_frame();
        logic [7:0] cs;
        sb.push_back(8'hA5);
        sb.push_back(8'(N));
        cs = 8'(N);
`ifdef FRAME_SEQ_EN
        sb.push_back(seq_m);
        cs = cs + seq_m;
        seq_m = seq_m + 8'd1;
`endif
        for (int i = 0; i < N; i++) begin
            sb.push_back(fd[i]);
            cs = cs + fd[i];
        end
        sb.push_back(cs);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || frame_busy) && n < 3000) begin
            tick();
            n++;
        end
        total++;
        assert (n < 3000) else begin
            bad++;
            $error("FAIL %s_timeout: got %0d cycles want <3000", tag, n);
        end
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
        chk("rst_tx_data", tx_data, 8'd0);
        chk("rst_busy", {7'd0, frame_busy}, 8'd0);
        chk("rst_overrun", overrun_cnt, 8'd0);
        reset = 1'b0;
        tick();

        // basic frame 01..10, csum 0x98 in the plain build
        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) fd[i] = 8'(i + 1);
        push_frame();
        scan(1'b1);
        chk("basic_busy_rise", {7'd0, frame_busy}, 8'd1);
        chk("basic_valid_rise", {7'd0, tx_valid}, 8'd1);
        chk("basic_hdr", tx_data, 8'hA5);
        wait_idle("basic");
        chk("basic_busy_fall", {7'd0, frame_busy}, 8'd0);
        chk("basic_valid_fall", {7'd0, tx_valid}, 8'd0);
        chk("basic_overrun", overrun_cnt, 8'd0);

        // backpressure: ready high one cycle in three
        tx_ready = 1'b0;
        for (int i = 0; i < N; i++) fd[i] = 8'(i * 7 + 3);
        push_frame();
        scan(1'b1);
        begin
            int c = 0;
            while ((sb.size() != 0 || frame_busy) && c < 3000) begin
                tx_ready = (c % 3 == 0);
                tick();
                c++;
            end
            total++;
            assert (c < 3000) else begin
                bad++;
                $error("FAIL bp_timeout: got %0d cycles want <3000", c);
            end
        end
        tx_ready = 1'b0;
        chk("bp_left", 8'(sb.size()), 8'd0);

        // overrun: second scan completes while the first waits at HDR
        for (int i = 0; i < N; i++) fd[i] = 8'(8'h40 + i);
        push_frame();
        scan(1'b1);
        for (int i = 0; i < N; i++) fd[i] = 8'hEE;
        scan(1'b1);
        chk("ovr_cnt", overrun_cnt, 8'd1);
        chk("ovr_valid", {7'd0, tx_valid}, 8'd1);
        chk("ovr_hdr", tx_data, 8'hA5);
        tx_ready = 1'b1;
        wait_idle("ovr");
        chk("ovr_cnt_after", overrun_cnt, 8'd1);

        // restart: partial scan discarded by start with a simultaneous sample
        for (int i = 0; i < 5; i++) send_sample(8'hFF, i == 0);
        for (int i = 0; i < N; i++) fd[i] = 8'h00;
        fd[0] = 8'h02;
        push_frame();
        scan(1'b1);
        wait_idle("restart");
        chk("restart_busy", {7'd0, frame_busy}, 8'd0);

        // free-running scan with no start pulse
        for (int i = 0; i < N; i++) fd[i] = 8'(8'hF0 - i);
        push_frame();
        scan(1'b0);
        wait_idle("freerun");

        // three back-to-back all-zero frames
        for (int i = 0; i < N; i++) fd[i] = 8'h00;
        for (int f = 0; f < 3; f++) begin
            push_frame();
            scan(1'b1);
            wait_idle("zero");
        end

        // reset while data byte 7 is on the wire
        for (int i = 0; i < N; i++) fd[i] = 8'(i + 8'h20);
        push_frame();
        scan(1'b1);
`ifdef FRAME_SEQ_EN
        repeat (10) tick();
`else
        repeat (9) tick();
`endif
        chk("mid_data7", tx_data, 8'h27);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", {7'd0, tx_valid}, 8'd0);
        chk("mid_rst_busy", {7'd0, frame_busy}, 8'd0);
        chk("mid_rst_overrun", overrun_cnt, 8'd0);
        reset = 1'b0;
        sb.delete();
        seq_m = 8'd0;
        repeat (3) tick();
        chk("mid_quiet", {7'd0, tx_valid}, 8'd0);

        // clean frame after reset
        for (int i = 0; i < N; i++) fd[i] = 8'($urandom_range(0, 255));
        push_frame();
        scan(1'b1);
        wait_idle("post_rst");
        chk("post_rst_left", 8'(sb.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
